// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes and
// datapath select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  // States that hold a memory request open and are guarded by the wait counter.
  function automatic logic is_wait(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory handshake, wait-timeout and
// illegal-opcode fault reporting.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       pcen,
  output logic       fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_q, hold_d;
  logic          wait_st, ready, tmo, illegal, pcwrite, branch;

  // hold_q marks the cycle after a timeout: the request is dropped and the
  // late mem_ready of the abandoned access is ignored.
  assign wait_st = is_wait(state_q);
  assign ready   = mem_ready && !hold_q;
  assign tmo     = wait_st && !hold_q && !mem_ready && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (ready) state_d = MEMWB; else if (tmo) state_d = FETCH;
      MEMWR:   if (ready || tmo) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase

    hold_d = tmo;
    // Any state change, including the FETCH->FETCH restart, starts a fresh wait.
    if (state_d != state_q || tmo)           cnt_d = '0;
    else if (wait_st && !hold_q && !mem_ready) cnt_d = cnt_q + CW'(1);
    else                                       cnt_d = cnt_q;
  end

  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    ALUOp    = ALUOP_ADD;
    PCSrc    = PCSRC_ALU;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_req = !hold_q;
        ALUSrcB = SRCB_FOUR;
        IRWrite = ready;
        pcwrite = ready;
      end
      DECODE: begin
        ALUSrcB = SRCB_SHIMM;
        illegal = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      ADDIWB:  RegWrite = 1'b1;
      JUMP: begin
        PCSrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase

    // Reset overrides the current state so nothing is committed that cycle.
    if (reset) begin
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
    end
    fault = (illegal || tmo) && !reset;
    pcen  = pcwrite || (branch && zero);
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16, is the maximum number of cycles a memory state waits for mem_ready before a fault is raised.
REQ-002 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: op  input  6  opcode field of the instruction register.
REQ-005 Port: zero  input  1  ALU zero flag.
REQ-006 Port: mem_ready  input  1  memory completes the current access this cycle.
REQ-007 Port: mem_req  output  1  memory access in progress.
REQ-008 Port: IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  datapath mux selects and write enables.
REQ-009 Port: ALUSrcB, ALUOp, PCSrc  output  2 each  ALU B select, ALU operation class (00 add, 01 sub, 10 funct), PC source (00 ALUResult, 01 ALUOut, 10 jump target).
REQ-010 Port: pcen  output  1  PC enable, equal to PCWrite OR (Branch AND zero).
REQ-011 Port: fault  output  1  one-cycle pulse on illegal opcode or memory timeout.

Function
REQ-012 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-013 Decoded opcodes SHALL be: 000000 R-type, 100011 LW, 101011 SW, 000100 BEQ, 001000 ADDI, 000010 J.
REQ-014 Every output not explicitly listed for a state SHALL be 0.
REQ-015 FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite and PCWrite SHALL be 1 only in the cycle mem_ready=1; advance to DECODE on mem_ready, otherwise stay.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state LW/SW->MEMADR, R-type->EXECUTE, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP.
REQ-017 DECODE with any other opcode SHALL pulse fault for one cycle and return to FETCH with no register, memory or PC write.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; LW->MEMRD, SW->MEMWR.
REQ-019 MEMRD: mem_req=1, IorD=1; advance to MEMWB on mem_ready, otherwise stay.
REQ-020 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-021 MEMWR: mem_req=1, IorD=1; MemWrite SHALL be 1 in every cycle of the state; advance to FETCH on mem_ready.
REQ-022 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB; ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1; next FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB; ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-025 JUMP: PCSrc=10, PCWrite=1; next FETCH.
REQ-026 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle mem_ready=0 within them.
REQ-027 When the counter reaches TIMEOUT-1 with mem_ready=0, the FSM SHALL pulse fault, deassert mem_req next cycle, and go to FETCH (from FETCH it restarts FETCH) without IRWrite, PCWrite or RegWrite.
REQ-028 mem_ready in the same cycle as timeout expiry SHALL take priority: the access completes, no fault.
REQ-029 Instruction latency with zero-wait memory: BEQ and J 3 cycles, R-type, ADDI and SW 4, LW 5.

Reset
REQ-030 With reset=1 at a clock edge the FSM SHALL enter FETCH, clear the wait counter and clear fault, regardless of current state.
REQ-031 During the reset cycle all write enables (IRWrite, PCWrite, MemWrite, RegWrite) and pcen SHALL be 0, including reset asserted mid-MEMWR.

Structure
REQ-032 The state enumeration, opcode constants and ALUOp/PCSrc/ALUSrcB encodings SHALL live in a shared package mips_pkg.
REQ-033 The block SHALL use no sub-module; next-state logic, output decode and wait counter are in one module.

Verification
REQ-034 Reset then op=100011, mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, then RegWrite=1 with MemtoReg=1 in cycle 5.
REQ-035 op=000100, zero=1 -> pcen=1 in BRANCH; zero=0 -> pcen=0; both return to FETCH in cycle 4.
REQ-036 op=101011, mem_ready held low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, FETCH follows the ready cycle.
REQ-037 TIMEOUT=16, mem_ready=0 in FETCH -> fault pulses once at cycle 16, IRWrite never 1, FSM restarts FETCH.
REQ-038 op=111111 -> fault pulse in DECODE, next state FETCH, no writes.
REQ-039 reset asserted in MEMWR -> MemWrite=0 in that cycle, FETCH next, counter zero.
